// File: rtl/sad_pkg.sv
// Shared definitions for the SAD scan sequencer and its raster counters.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FLUSH
  } scanState_e;

  localparam int unsigned SAD_W_DEF   = 32;
  localparam int unsigned COORD_W_DEF = 6;

  // Seed for the working minimum; truncated to SAD_W at the point of use.
  localparam logic [63:0] SAD_MAX = '1;

endpackage

// File: rtl/sad_scan_ctrl_if.sv
// Request/result handshake between the scan sequencer and the SAD pipeline.
interface sad_scan_ctrl_if #(
  parameter int unsigned COORD_W = 6,
  parameter int unsigned SAD_W   = 32
) ();

  logic               ReqValid;
  logic               ReqReady;
  logic [COORD_W-1:0] ReqX;
  logic [COORD_W-1:0] ReqY;
  logic               ResultValid;
  logic [SAD_W-1:0]   ResultSAD;

  modport master (
    output ReqValid, ReqX, ReqY,
    input  ReqReady, ResultValid, ResultSAD
  );

  modport slave (
    input  ReqValid, ReqX, ReqY,
    output ReqReady, ResultValid, ResultSAD
  );

endinterface

// File: rtl/sad_raster_cnt.sv
// Raster x/y position counter: x wraps at COLS-1 into y+1, Last marks the final position.
module sad_raster_cnt #(
  parameter int unsigned COLS    = 61,
  parameter int unsigned ROWS    = 61,
  parameter int unsigned COORD_W = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               Advance,
  output logic [COORD_W-1:0] PosX,
  output logic [COORD_W-1:0] PosY,
  output logic               Last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(ROWS - 1);

  logic lastX;

  assign lastX = (PosX == X_MAX);
  assign Last  = lastX && (PosY == Y_MAX);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PosX <= '0;
      PosY <= '0;
    end else if (Clear) begin
      PosX <= '0;
      PosY <= '0;
    end else if (Advance) begin
      if (lastX) begin
        PosX <= '0;
        PosY <= Last ? '0 : PosY + 1'b1;
      end else begin
        PosX <= PosX + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sad_scan_ctrl.sv
// SAD scan sequencer: raster-issues candidate positions with a bounded in-flight
// count, tracks the minimum of in-order results and publishes it with a Done pulse.
module sad_scan_ctrl
  import sad_pkg::*;
#(
  parameter int unsigned COLS    = 61,
  parameter int unsigned ROWS    = 61,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned SAD_W   = SAD_W_DEF,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Abort,
  sad_scan_ctrl_if.master     sadBus,
  output logic                Busy,
  output logic                Done,
  output logic [SAD_W-1:0]    MinSAD,
  output logic [COORD_W-1:0]  MinX,
  output logic [COORD_W-1:0]  MinY
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  scanState_e         state;
  logic [OUT_W-1:0]   outstanding;
  logic [OUT_W-1:0]   outNext;
  logic [SAD_W-1:0]   workMin;
  logic [COORD_W-1:0] workX;
  logic [COORD_W-1:0] workY;
  logic [SAD_W-1:0]   nextMin;
  logic [COORD_W-1:0] nextX;
  logic [COORD_W-1:0] nextY;

  logic               scanStart;
  logic               xfer;
  logic               resAccept;
  logic [COORD_W-1:0] issueX;
  logic [COORD_W-1:0] issueY;
  logic               issueLast;
  logic [COORD_W-1:0] resX;
  logic [COORD_W-1:0] resY;
  logic               resLast;

  assign scanStart = (state == IDLE) && Start;

  // Abort masks the request combinationally so an aborting cycle never transfers.
  assign sadBus.ReqValid = (state == ISSUE) && (outstanding < OUT_W'(MAX_OUT)) && !Abort;
  assign sadBus.ReqX     = issueX;
  assign sadBus.ReqY     = issueY;

  assign xfer      = sadBus.ReqValid && sadBus.ReqReady;
  assign resAccept = sadBus.ResultValid && (outstanding != '0);
  assign Busy      = (state != IDLE);

  sad_raster_cnt #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .COORD_W (COORD_W)
  ) issueCnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clear   (scanStart),
    .Advance (xfer),
    .PosX    (issueX),
    .PosY    (issueY),
    .Last    (issueLast)
  );

  sad_raster_cnt #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .COORD_W (COORD_W)
  ) resultCnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clear   (scanStart),
    .Advance (resAccept),
    .PosX    (resX),
    .PosY    (resY),
    .Last    (resLast)
  );

  always_comb begin
    outNext = outstanding;
    if (xfer && !resAccept) begin
      outNext = outstanding + 1'b1;
    end else if (!xfer && resAccept) begin
      outNext = outstanding - 1'b1;
    end
  end

  // Strict compare keeps the earliest raster position on ties.
  always_comb begin
    nextMin = workMin;
    nextX   = workX;
    nextY   = workY;
    if (resAccept && (sadBus.ResultSAD < workMin)) begin
      nextMin = sadBus.ResultSAD;
      nextX   = resX;
      nextY   = resY;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      outstanding <= '0;
      workMin     <= '0;
      workX       <= '0;
      workY       <= '0;
      Done        <= 1'b0;
      MinSAD      <= '0;
      MinX        <= '0;
      MinY        <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            outstanding <= '0;
            workMin     <= SAD_W'(SAD_MAX);
            workX       <= '0;
            workY       <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          outstanding <= outNext;
          workMin     <= nextMin;
          workX       <= nextX;
          workY       <= nextY;
          if (Abort) begin
            state <= FLUSH;
          end else if (xfer && issueLast) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          outstanding <= outNext;
          workMin     <= nextMin;
          workX       <= nextX;
          workY       <= nextY;
          if (Abort) begin
            state <= FLUSH;
          end else if (resAccept && resLast) begin
            MinSAD <= nextMin;
            MinX   <= nextX;
            MinY   <= nextY;
            Done   <= 1'b1;
            state  <= IDLE;
          end
        end
        FLUSH: begin
          outstanding <= outNext;
          if (outNext == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_scan_ctrl.sv
// Directed bench for sad_scan_ctrl on a 3x2 raster with at most 2 requests in flight.
module tb_sad_scan_ctrl;

  localparam int unsigned COLS    = 3;
  localparam int unsigned ROWS    = 2;
  localparam int unsigned COORD_W = 2;
  localparam int unsigned SAD_W   = 16;
  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned NPOS    = COLS * ROWS;

  typedef struct {
    int unsigned      due;
    logic [SAD_W-1:0] sad;
  } pipe_t;

  typedef struct {
    logic [SAD_W-1:0]   sad;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } res_t;

  logic               Clk = 1'b0;
  logic               Reset = 1'b0;
  logic               Start = 1'b0;
  logic               Abort = 1'b0;
  logic               Busy;
  logic               Done;
  logic [SAD_W-1:0]   MinSAD;
  logic [COORD_W-1:0] MinX;
  logic [COORD_W-1:0] MinY;

  sad_scan_ctrl_if #(.COORD_W(COORD_W), .SAD_W(SAD_W)) bus ();

  sad_scan_ctrl #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .COORD_W (COORD_W),
    .SAD_W   (SAD_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Abort  (Abort),
    .sadBus (bus),
    .Busy   (Busy),
    .Done   (Done),
    .MinSAD (MinSAD),
    .MinX   (MinX),
    .MinY   (MinY)
  );

  always #5 Clk = ~Clk;

  pipe_t            pipe[$];
  res_t             sb[$];
  logic [SAD_W-1:0] sadTable [NPOS];
  int unsigned      cyc, lat, mstate, expX, expY, dutXfers, doneSeen;
  bit               randReady, strayResult;
  logic [SAD_W-1:0] lastSAD;
  logic [COORD_W-1:0] lastX, lastY;
  int unsigned      total, bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t bestOf();
    res_t b;
    b.sad = '1;
    b.x   = '0;
    b.y   = '0;
    for (int i = 0; i < int'(NPOS); i++) begin
      if (sadTable[i] < b.sad) begin
        b.sad = sadTable[i];
        b.x   = COORD_W'(i % int'(COLS));
        b.y   = COORD_W'(i / int'(COLS));
      end
    end
    return b;
  endfunction

  // One clock: drive ReqReady/results, check request side, advance the reference
  // state, then check Busy/Done/Min after the edge.
  task automatic tick();
    bit          expRV, expXfer, acc, expDone;
    int unsigned inFlight, outNext;
    pipe_t       pe;
    res_t        r;
    bus.ReqReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    inFlight = pipe.size();
    expRV = (mstate == 1) && (inFlight < MAX_OUT) && !Abort;
    check("ReqValid", 32'(bus.ReqValid), 32'(expRV));
    if (expRV) begin
      check("ReqX", 32'(bus.ReqX), expX);
      check("ReqY", 32'(bus.ReqY), expY);
    end
    expXfer = expRV && bus.ReqReady;
    if (bus.ReqValid && bus.ReqReady) dutXfers++;
    acc = 1'b0;
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      bus.ResultValid = 1'b1;
      bus.ResultSAD   = pipe[0].sad;
      void'(pipe.pop_front());
      acc = 1'b1;
    end else if (strayResult) begin
      bus.ResultValid = 1'b1;
      bus.ResultSAD   = '0;
    end else begin
      bus.ResultValid = 1'b0;
      bus.ResultSAD   = SAD_W'($urandom);
    end
    if (expXfer) begin
      pe.due = cyc + lat;
      pe.sad = sadTable[expY * COLS + expX];
      pipe.push_back(pe);
    end
    outNext = inFlight + int'(expXfer) - int'(acc);
    expDone = 1'b0;
    case (mstate)
      0: if (Start) begin
        mstate = 1;
        expX   = 0;
        expY   = 0;
        sb.push_back(bestOf());
      end
      1: if (Abort) begin
        mstate = 3;
        void'(sb.pop_back());
      end else if (expXfer) begin
        if (expX == COLS - 1 && expY == ROWS - 1) mstate = 2;
        if (expX == COLS - 1) begin
          expX = 0;
          expY = (expY == ROWS - 1) ? 0 : expY + 1;
        end else begin
          expX++;
        end
      end
      2: if (Abort) begin
        mstate = 3;
        void'(sb.pop_back());
      end else if (acc && inFlight == 1) begin
        mstate  = 0;
        expDone = 1'b1;
      end
      default: if (outNext == 0) mstate = 0;
    endcase
    @(posedge Clk);
    #1;
    cyc++;
    if (Done === 1'b1) doneSeen++;
    check("Busy", 32'(Busy), 32'(mstate != 0));
    check("Done", 32'(Done), 32'(expDone));
    if (expDone && sb.size() > 0) begin
      r = sb.pop_front();
      lastSAD = r.sad;
      lastX   = r.x;
      lastY   = r.y;
    end
    check("MinSAD", 32'(MinSAD), 32'(lastSAD));
    check("MinX", 32'(MinX), 32'(lastX));
    check("MinY", 32'(MinY), 32'(lastY));
  endtask

  task automatic runScan(input int unsigned latency, input bit rnd, input bit startAgain);
    int unsigned d0;
    lat       = latency;
    randReady = rnd;
    dutXfers  = 0;
    d0        = doneSeen;
    Start = 1'b1;
    tick();
    for (int n = 0; n < 300 && mstate != 0; n++) begin
      Start = startAgain && (n == 2);
      tick();
    end
    Start = 1'b0;
    check("scanTimeout", 32'(Busy), 32'(0));
    check("scanXfers", dutXfers, NPOS);
    check("doneOnce", doneSeen - d0, 1);
  endtask

  initial begin
    int unsigned d0;
    total = 0;
    bad   = 0;
    cyc   = 0;
    mstate = 0;
    expX = 0;
    expY = 0;
    lat  = 2;
    doneSeen = 0;
    dutXfers = 0;
    randReady = 1'b0;
    strayResult = 1'b0;
    lastSAD = '0;
    lastX = '0;
    lastY = '0;
    bus.ReqReady    = 1'b0;
    bus.ResultValid = 1'b0;
    bus.ResultSAD   = '0;

    repeat (2) @(posedge Clk);
    #1;
    check("rstReqValid", 32'(bus.ReqValid), 0);
    check("rstReqX", 32'(bus.ReqX), 0);
    check("rstReqY", 32'(bus.ReqY), 0);
    check("rstBusy", 32'(Busy), 0);
    check("rstDone", 32'(Done), 0);
    check("rstMinSAD", 32'(MinSAD), 0);
    check("rstMinX", 32'(MinX), 0);
    check("rstMinY", 32'(MinY), 0);
    Reset = 1'b1;

    strayResult = 1'b1;
    tick();
    strayResult = 1'b0;

    sadTable = '{16'd9, 16'd7, 16'd8, 16'd7, 16'd5, 16'd6};
    runScan(2, 1'b0, 1'b1);
    check("scan1MinSAD", 32'(MinSAD), 5);
    check("scan1MinX", 32'(MinX), 1);
    check("scan1MinY", 32'(MinY), 1);

    sadTable = '{16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4};
    runScan(2, 1'b0, 1'b0);
    check("tieMinX", 32'(MinX), 0);
    check("tieMinY", 32'(MinY), 0);

    sadTable = '{16'd12, 16'd3, 16'd15, 16'd3, 16'd8, 16'd9};
    runScan(5, 1'b0, 1'b0);

    for (int i = 0; i < int'(NPOS); i++) sadTable[i] = SAD_W'($urandom_range(0, 1000));
    runScan(3, 1'b1, 1'b0);

    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    sadTable = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    lat = 3;
    randReady = 1'b0;
    dutXfers = 0;
    d0 = doneSeen;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 0; n < 50 && dutXfers < 3; n++) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    for (int n = 0; n < 50 && mstate != 0; n++) tick();
    tick();
    check("abortIdle", 32'(Busy), 0);
    check("abortNoDone", doneSeen - d0, 0);
    check("abortXfers", dutXfers, 3);

    sadTable = '{16'd30, 16'd20, 16'd10, 16'd40, 16'd50, 16'd60};
    lat = 5;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 0; n < 100 && mstate != 2; n++) tick();
    Reset = 1'b0;
    bus.ResultValid = 1'b0;
    #1;
    check("midRstBusy", 32'(Busy), 0);
    check("midRstDone", 32'(Done), 0);
    check("midRstReqValid", 32'(bus.ReqValid), 0);
    check("midRstReqX", 32'(bus.ReqX), 0);
    check("midRstReqY", 32'(bus.ReqY), 0);
    check("midRstMinSAD", 32'(MinSAD), 0);
    check("midRstMinX", 32'(MinX), 0);
    check("midRstMinY", 32'(MinY), 0);
    pipe.delete();
    sb.delete();
    mstate = 0;
    expX = 0;
    expY = 0;
    lastSAD = '0;
    lastX = '0;
    lastY = '0;
    @(posedge Clk);
    #1;
    cyc++;
    Reset = 1'b1;
    runScan(2, 1'b0, 1'b0);
    check("postRstMinSAD", 32'(MinSAD), 10);
    check("postRstMinX", 32'(MinX), 2);
    check("postRstMinY", 32'(MinY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
